servio_wmux: RTL and testbench
==============================

# servio_wmux

Byte-serial write multiplexer for the servio memory subsystem. It arbitrates four Wishbone write ports (one per hart) onto one byte-wide Avalon-MM write master. Arbitration is time-sliced by the shared 6-bit cycle slot stream, using the same slot decode as the instruction-fetch read mux. Each granted 32-bit store becomes up to four registered byte writes and one single-cycle ack, so store traffic shares the frame schedule with fetch traffic.

## Interface
- DATA_DEPTH, 1024, byte depth of target memory; aw = $clog2(DATA_DEPTH).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; 0 resets on the next rising clk edge.
- wb_sN_adr  in  32  byte address for port N (N = 0..3); bits [aw-1:2] are used.
- wb_sN_dat  in  32  write data for port N; lane k = dat[8k+7:8k].
- wb_sN_sel  in  4  byte enables for port N.
- wb_sN_we  in  1  write strobe for port N; cycles with we=0 are ignored and never acked.
- wb_sN_cyc  in  1  cycle request for port N.
- wb_sN_ack  out  1  registered one-cycle store-complete pulse for port N.
- avm_s4_address  out  aw  registered byte address.
- avm_s4_write  out  1  registered write strobe.
- avm_s4_writedata  out  8  registered byte data.
- asi_cyc_data  in  6  slot index from the slot counter.
- asi_cyc_valid  in  1  slot index valid.
- aso_cyc_data  out  6  asi_cyc_data delayed one cycle, aligned to the Avalon outputs.
- aso_cyc_valid  out  1  asi_cyc_valid delayed one cycle.

## Operation
- Slot decode per cycle:
  - active = asi_cyc_valid & (asi_cyc_data[5:4]==0).
  - port p = asi_cyc_data[3:2].
  - lane k = asi_cyc_data[1:0].
- Hold state: busy, hport[1:0], hadr[aw-3:0], hdat[31:0], hsel[3:0].
- Lane 0, active, wb_sp_cyc & wb_sp_we:
  - capture p, adr[aw-1:2], dat and sel into the hold registers;
  - set busy;
  - issue lane-0 byte: address {adr[aw-1:2],2'd0}, write = sel[0], writedata = dat[7:0].
- Lanes 1..3, active, busy & hport==p & wb_sp_cyc:
  - issue byte k from the hold registers: address {hadr,k}, write = hsel[k], writedata = hdat[8k+7:8k].
- Lane 3 under the same conditions: also assert wb_sp_ack for one cycle and clear busy.
- All-zero sel: no Avalon writes are issued; the ack is still returned at lane 3.
- Abort: busy clears with no ack and no further writes in any of these cases:
  - wb_sp_cyc low at lanes 1..3;
  - asi_cyc_valid low while busy;
  - out-of-sequence slot while busy (p≠hport, or lane not equal to previous lane+1).
- The master retries on a later frame; rewriting the same bytes is harmless.
- A request raised after its port's lane-0 slot waits for the next frame. Only the lane-0 sample starts a store.
- Every cycle with no byte issued: avm_s4_write=0; address and writedata hold their last value.
- aso_cyc_* = registered copy of asi_cyc_*.

## Timing
- Reset values:
  - all wb_sN_ack, avm_s4_write, avm_s4_address, avm_s4_writedata = 0;
  - aso_cyc_data = 0, aso_cyc_valid = 0;
  - busy = 0.
- Reset mid-store drops the store silently; no ack is issued.
- With t0 = the lane-0 cycle, byte k is visible on Avalon at t0+k+1, and ack is high during t0+4 only.
- wb_sp_ack and the lane-3 write appear on the same cycle.
- The next lane 0 for the same port is ≥16 slots later. The master must drop cyc or present a new store by then.
- Avalon target is assumed always-ready (no waitrequest); one byte per cycle max.
- Simultaneous requests on all four ports are served in slot order, one 4-cycle window each.

## Test plan
- Port 0: adr=0x10, dat=0xA1B2C3D4, sel=0xF, slots 0..3 -> writes (0x10,D4),(0x11,C3),(0x12,B2),(0x13,A1) on cycles t0+1..t0+4; wb_s0_ack=1 only at t0+4.
- Port 2: sel=0x5, dat=0x11223344, adr=0x20, slots 8..11 -> writes only (0x20,44),(0x22,22); ack at t0+4; writes 0x21/0x23 absent.
- Port 1: we=0, cyc=1 through slots 4..7 -> no avm_s4_write, no ack.
- Port 3 drops cyc at lane 2 -> lane 0–1 writes only; no ack; the retry in the next frame completes with ack.
- reset=0 asserted at lane 1 of a port-0 store -> next cycle all outputs 0, busy 0, no ack; slots 16..63 -> no writes.
- All four ports request over slots 0..15 -> 16 writes in port order, one ack per port at its lane-3+1 cycle; aso_cyc_data lags asi_cyc_data by exactly 1.

Source files
------------

// File: rtl/servio_wmux.sv
// servio_wmux: four Wishbone write ports time-sliced onto one byte-wide
// Avalon-MM write master. Slot stream: [5:4]==0 active, [3:2] port, [1:0] lane.
// A store is captured on its port's lane-0 slot and then streamed out as one
// byte per lane. The ack is returned together with the lane-3 byte.
module servio_wmux #(
  parameter  int DATA_DEPTH = 1024,
  localparam int AW         = $clog2(DATA_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   wb_s0_adr,
  input  logic [31:0]   wb_s0_dat,
  input  logic [3:0]    wb_s0_sel,
  input  logic          wb_s0_we,
  input  logic          wb_s0_cyc,
  output logic          wb_s0_ack,
  input  logic [31:0]   wb_s1_adr,
  input  logic [31:0]   wb_s1_dat,
  input  logic [3:0]    wb_s1_sel,
  input  logic          wb_s1_we,
  input  logic          wb_s1_cyc,
  output logic          wb_s1_ack,
  input  logic [31:0]   wb_s2_adr,
  input  logic [31:0]   wb_s2_dat,
  input  logic [3:0]    wb_s2_sel,
  input  logic          wb_s2_we,
  input  logic          wb_s2_cyc,
  output logic          wb_s2_ack,
  input  logic [31:0]   wb_s3_adr,
  input  logic [31:0]   wb_s3_dat,
  input  logic [3:0]    wb_s3_sel,
  input  logic          wb_s3_we,
  input  logic          wb_s3_cyc,
  output logic          wb_s3_ack,
  output logic [AW-1:0] avm_s4_address,
  output logic          avm_s4_write,
  output logic [7:0]    avm_s4_writedata,
  input  logic [5:0]    asi_cyc_data,
  input  logic          asi_cyc_valid,
  output logic [5:0]    aso_cyc_data,
  output logic          aso_cyc_valid
);

  // Store being streamed out. lane is the last lane issued for it.
  typedef struct packed {
    logic          busy;
    logic [1:0]    port;
    logic [1:0]    lane;
    logic [AW-3:0] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
  } hold_t;

  hold_t hold;

  logic [3:0][31:0] req_adr, req_dat;
  logic [3:0][3:0]  req_sel;
  logic [3:0]       req_we, req_cyc;
  logic [3:0]       ack_q;

  assign req_adr = {wb_s3_adr, wb_s2_adr, wb_s1_adr, wb_s0_adr};
  assign req_dat = {wb_s3_dat, wb_s2_dat, wb_s1_dat, wb_s0_dat};
  assign req_sel = {wb_s3_sel, wb_s2_sel, wb_s1_sel, wb_s0_sel};
  assign req_we  = {wb_s3_we,  wb_s2_we,  wb_s1_we,  wb_s0_we};
  assign req_cyc = {wb_s3_cyc, wb_s2_cyc, wb_s1_cyc, wb_s0_cyc};

  assign wb_s0_ack = ack_q[0];
  assign wb_s1_ack = ack_q[1];
  assign wb_s2_ack = ack_q[2];
  assign wb_s3_ack = ack_q[3];

  // Address bits above the memory and the byte offset are not needed.
  logic [3:0] unused_adr;
  for (genvar i = 0; i < 4; i++) begin : g_unused
    assign unused_adr[i] = ^{req_adr[i][31:AW], req_adr[i][1:0]};
  end

  logic          slot_act;
  logic [1:0]    slot_p, slot_k;
  logic          start, cont;
  logic          issue_wr;
  logic [AW-1:0] issue_adr;
  logic [7:0]    issue_dat;

  assign slot_act = asi_cyc_valid && (asi_cyc_data[5:4] == 2'd0);
  assign slot_p   = asi_cyc_data[3:2];
  assign slot_k   = asi_cyc_data[1:0];

  // Slot decode: start a new store on lane 0, or continue the held one when
  // the slot is exactly the next lane of the same port and cyc is still up.
  always_comb begin
    start     = slot_act && (slot_k == 2'd0) && req_cyc[slot_p] && req_we[slot_p];
    cont      = hold.busy && slot_act && (slot_k != 2'd0) && (slot_p == hold.port)
                && (slot_k == hold.lane + 2'd1) && req_cyc[slot_p];
    issue_wr  = 1'b0;
    issue_adr = {hold.adr, slot_k};
    issue_dat = hold.dat[{slot_k, 3'b000} +: 8];
    if (start) begin
      issue_wr  = req_sel[slot_p][0];
      issue_adr = {req_adr[slot_p][AW-1:2], 2'd0};
      issue_dat = req_dat[slot_p][7:0];
    end else if (cont) begin
      issue_wr  = hold.sel[slot_k];
    end
  end

  // Hold state, registered Avalon/ack outputs and the slot-stream delay.
  // Any slot that neither starts nor continues a store aborts it silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold             <= '0;
      ack_q            <= '0;
      avm_s4_write     <= 1'b0;
      avm_s4_address   <= '0;
      avm_s4_writedata <= '0;
      aso_cyc_data     <= '0;
      aso_cyc_valid    <= 1'b0;
    end else begin
      aso_cyc_data  <= asi_cyc_data;
      aso_cyc_valid <= asi_cyc_valid;
      avm_s4_write  <= issue_wr;
      ack_q         <= '0;
      if (issue_wr) begin
        avm_s4_address   <= issue_adr;
        avm_s4_writedata <= issue_dat;
      end
      if (start) begin
        hold.busy <= 1'b1;
        hold.port <= slot_p;
        hold.lane <= 2'd0;
        hold.adr  <= req_adr[slot_p][AW-1:2];
        hold.dat  <= req_dat[slot_p];
        hold.sel  <= req_sel[slot_p];
      end else if (cont) begin
        hold.lane <= slot_k;
        if (slot_k == 2'd3) begin
          hold.busy     <= 1'b0;
          ack_q[slot_p] <= 1'b1;
        end
      end else begin
        hold.busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_servio_wmux.sv
// Bench for servio_wmux: directed slot frames, a look-back history model
// checked every cycle, and literal expectations for the listed scenarios.
module tb_servio_wmux;
  localparam int NMAX = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr [4];
  logic [31:0] dat [4];
  logic [3:0]  sel [4];
  logic        we  [4];
  logic        cyc [4];
  logic [3:0]  ack;
  logic [9:0]  avm_s4_address;
  logic        avm_s4_write;
  logic [7:0]  avm_s4_writedata;
  logic [5:0]  asi_cyc_data, aso_cyc_data;
  logic        asi_cyc_valid, aso_cyc_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  servio_wmux #(.DATA_DEPTH(1024)) dut (
    .clk(clk), .reset(reset),
    .wb_s0_adr(adr[0]), .wb_s0_dat(dat[0]), .wb_s0_sel(sel[0]), .wb_s0_we(we[0]), .wb_s0_cyc(cyc[0]), .wb_s0_ack(ack[0]),
    .wb_s1_adr(adr[1]), .wb_s1_dat(dat[1]), .wb_s1_sel(sel[1]), .wb_s1_we(we[1]), .wb_s1_cyc(cyc[1]), .wb_s1_ack(ack[1]),
    .wb_s2_adr(adr[2]), .wb_s2_dat(dat[2]), .wb_s2_sel(sel[2]), .wb_s2_we(we[2]), .wb_s2_cyc(cyc[2]), .wb_s2_ack(ack[2]),
    .wb_s3_adr(adr[3]), .wb_s3_dat(dat[3]), .wb_s3_sel(sel[3]), .wb_s3_we(we[3]), .wb_s3_cyc(cyc[3]), .wb_s3_ack(ack[3]),
    .avm_s4_address(avm_s4_address), .avm_s4_write(avm_s4_write), .avm_s4_writedata(avm_s4_writedata),
    .asi_cyc_data(asi_cyc_data), .asi_cyc_valid(asi_cyc_valid),
    .aso_cyc_data(aso_cyc_data), .aso_cyc_valid(aso_cyc_valid)
  );

  // ---------------- history model ----------------
  // A byte for lane k of port p is written at cycle n iff cycles n-k..n carry
  // the consecutive slots (p,0)..(p,k), valid, out of reset, cyc high, and
  // the lane-0 cycle had we high. Store fields come from the lane-0 cycle.
  logic        h_rst [NMAX];
  logic        h_v   [NMAX];
  logic [5:0]  h_s   [NMAX];
  logic [3:0]  h_cyc [NMAX];
  logic [3:0]  h_we  [NMAX];
  logic [31:0] h_adr [NMAX][4];
  logic [31:0] h_dat [NMAX][4];
  logic [3:0]  h_sel [NMAX][4];

  logic [3:0] e_ack;
  logic       e_wr, e_av;
  logic [9:0] e_addr;
  logic [7:0] e_dat;
  logic [5:0] e_ad;

  initial begin
    int n;
    n = 0;
    e_addr = '0;
    e_dat  = '0;
    forever begin
      @(posedge clk);
      h_rst[n] = reset; h_v[n] = asi_cyc_valid; h_s[n] = asi_cyc_data;
      for (int q = 0; q < 4; q++) begin
        h_cyc[n][q] = cyc[q]; h_we[n][q] = we[q];
        h_adr[n][q] = adr[q]; h_dat[n][q] = dat[q]; h_sel[n][q] = sel[q];
      end
      e_ack = '0; e_wr = 1'b0;
      if (!h_rst[n]) begin
        e_addr = '0; e_dat = '0; e_ad = '0; e_av = 1'b0;
      end else begin
        int k, p, t0;
        bit ok;
        e_ad = h_s[n]; e_av = h_v[n];
        k  = int'(h_s[n][1:0]);
        p  = int'(h_s[n][3:2]);
        ok = (n >= k);
        t0 = n - k;
        for (int j = 0; j <= k; j++) begin
          if (ok) begin
            int m;
            m = t0 + j;
            ok = h_rst[m] && h_v[m] && (h_s[m] == {2'b00, 2'(p), 2'(j)}) && h_cyc[m][p];
          end
        end
        if (ok) ok = h_we[t0][p];
        if (ok && h_sel[t0][p][k]) begin
          e_wr   = 1'b1;
          e_addr = {h_adr[t0][p][9:2], 2'(k)};
          e_dat  = h_dat[t0][p][8*k +: 8];
        end
        if (ok && k == 3) e_ack[p] = 1'b1;
      end
      #1;
      checks++;
      if ({ack, avm_s4_write, avm_s4_address, avm_s4_writedata, aso_cyc_data, aso_cyc_valid} !==
          {e_ack, e_wr, e_addr, e_dat, e_ad, e_av}) begin
        errors++;
        $display("FAIL model cyc%0d actual ack=%b wr=%b a=%h d=%h aso=%h/%b required ack=%b wr=%b a=%h d=%h aso=%h/%b",
                 n, ack, avm_s4_write, avm_s4_address, avm_s4_writedata, aso_cyc_data, aso_cyc_valid,
                 e_ack, e_wr, e_addr, e_dat, e_ad, e_av);
      end
      n++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic slot(input logic v, input logic [5:0] s);
    @(negedge clk);
    asi_cyc_valid = v;
    asi_cyc_data  = s;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Checks the byte produced by the previous slot.
  task automatic chk_wr(input string nm, input logic w, input logic [9:0] a, input logic [7:0] d);
    lit({nm, "_wr"}, 32'(avm_s4_write), 32'(w));
    if (w) begin
      lit({nm, "_adr"}, 32'(avm_s4_address), 32'(a));
      lit({nm, "_dat"}, 32'(avm_s4_writedata), 32'(d));
    end
  endtask

  initial begin
    int nwr;
    reset = 1'b0; asi_cyc_valid = 1'b0; asi_cyc_data = '0;
    for (int q = 0; q < 4; q++) begin
      adr[q] = '0; dat[q] = '0; sel[q] = '0; we[q] = 1'b0; cyc[q] = 1'b0;
    end
    repeat (3) @(negedge clk);
    lit("rst_out", {ack, avm_s4_write, avm_s4_address, avm_s4_writedata, aso_cyc_data, aso_cyc_valid}, '0);
    reset = 1'b1;

    // Frame 1: port 0 full store, port 1 read-only cyc, port 2 sparse sel,
    // port 3 drops cyc at lane 2.
    adr[0] = 32'h10; dat[0] = 32'hA1B2C3D4; sel[0] = 4'hF; we[0] = 1'b1; cyc[0] = 1'b1;
    adr[1] = 32'h30; dat[1] = 32'h99887766; sel[1] = 4'hF; we[1] = 1'b0; cyc[1] = 1'b1;
    adr[2] = 32'h20; dat[2] = 32'h11223344; sel[2] = 4'h5; we[2] = 1'b1; cyc[2] = 1'b1;
    adr[3] = 32'h40; dat[3] = 32'hDEADBEEF; sel[3] = 4'hF; we[3] = 1'b1; cyc[3] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      slot(1'b1, 6'(i));
      case (i)
        1:  begin chk_wr("p0_b0", 1, 10'h10, 8'hD4); lit("p0_ack_b0", 32'(ack), 0); end
        2:  chk_wr("p0_b1", 1, 10'h11, 8'hC3);
        3:  begin chk_wr("p0_b2", 1, 10'h12, 8'hB2); lit("p0_ack_b2", 32'(ack), 0); end
        4:  begin chk_wr("p0_b3", 1, 10'h13, 8'hA1); lit("p0_ack", 32'(ack), 32'h1); cyc[0] = 1'b0; end
        5:  begin lit("p0_ack_off", 32'(ack), 0); chk_wr("p1_l0", 0, 0, 0); end
        8:  begin chk_wr("p1_l3", 0, 0, 0); lit("p1_noack", 32'(ack), 0); cyc[1] = 1'b0; end
        9:  chk_wr("p2_b0", 1, 10'h20, 8'h44);
        10: begin chk_wr("p2_b1", 0, 0, 0); lit("p2_hold_adr", 32'(avm_s4_address), 32'h20); end
        11: chk_wr("p2_b2", 1, 10'h22, 8'h22);
        12: begin chk_wr("p2_b3", 0, 0, 0); lit("p2_ack", 32'(ack), 32'h4); cyc[2] = 1'b0; end
        13: chk_wr("p3_b0", 1, 10'h40, 8'hEF);
        14: begin chk_wr("p3_b1", 1, 10'h41, 8'hBE); cyc[3] = 1'b0; end
        15: chk_wr("p3_abort_b2", 0, 0, 0);
        16: begin chk_wr("p3_abort_b3", 0, 0, 0); lit("p3_noack", 32'(ack), 0); end
        default: ;
      endcase
    end

    // Frame 2: port 3 retries and completes.
    cyc[3] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      slot(1'b1, 6'(i));
      case (i)
        13: chk_wr("p3r_b0", 1, 10'h40, 8'hEF);
        14: chk_wr("p3r_b1", 1, 10'h41, 8'hBE);
        15: chk_wr("p3r_b2", 1, 10'h42, 8'hAD);
        16: begin chk_wr("p3r_b3", 1, 10'h43, 8'hDE); lit("p3r_ack", 32'(ack), 32'h8); cyc[3] = 1'b0; end
        default: ;
      endcase
    end

    // Frame 3: reset asserted on lane 1 of a port-0 store.
    adr[0] = 32'h10; dat[0] = 32'h55667788; sel[0] = 4'hF; we[0] = 1'b1; cyc[0] = 1'b1;
    nwr = 0;
    for (int i = 0; i < 64; i++) begin
      slot(1'b1, 6'(i));
      if (i == 1) begin chk_wr("rs_b0", 1, 10'h10, 8'h88); reset = 1'b0; end
      if (i == 2) begin
        reset = 1'b1;
        lit("rs_out", {ack, avm_s4_write, avm_s4_address, avm_s4_writedata, aso_cyc_data, aso_cyc_valid}, '0);
      end
      if (i == 4) begin lit("rs_noack", 32'(ack), 0); cyc[0] = 1'b0; end
      if (i >= 17 && avm_s4_write) nwr++;
    end
    lit("rs_nowrites", 32'(nwr), 0);

    // Frame 4: all four ports at once, served in slot order.
    for (int q = 0; q < 4; q++) begin
      adr[q] = 32'h100 + 32'(4 * q);
      dat[q] = {8'(4*q+3), 8'(4*q+2), 8'(4*q+1), 8'(4*q)};
      sel[q] = 4'hF; we[q] = 1'b1; cyc[q] = 1'b1;
    end
    for (int i = 0; i < 64; i++) begin
      slot(1'b1, 6'(i));
      if (i >= 1 && i <= 16) begin
        chk_wr($sformatf("all_b%0d", i - 1), 1, 10'(32'h100 + i - 1), 8'(i - 1));
        lit($sformatf("all_ack%0d", i), 32'(ack), (i % 4 == 0) ? (32'h1 << (i / 4 - 1)) : 32'h0);
        lit($sformatf("all_aso%0d", i), 32'({aso_cyc_valid, aso_cyc_data}), 32'({1'b1, 6'(i - 1)}));
      end
      if (i == 16) for (int q = 0; q < 4; q++) cyc[q] = 1'b0;
    end

    // Frame 5: valid drops mid-store on port 0; remaining lanes are ignored.
    adr[0] = 32'h80; dat[0] = 32'h44332211; sel[0] = 4'hF; cyc[0] = 1'b1;
    slot(1'b1, 6'd0);
    slot(1'b1, 6'd1); chk_wr("vd_b0", 1, 10'h80, 8'h11);
    slot(1'b0, 6'd2); chk_wr("vd_b1", 1, 10'h81, 8'h22);
    slot(1'b1, 6'd2); chk_wr("vd_gap", 0, 0, 0);
    slot(1'b1, 6'd3); chk_wr("vd_b2", 0, 0, 0);
    slot(1'b1, 6'd4); chk_wr("vd_b3", 0, 0, 0); lit("vd_noack", 32'(ack), 0);
    cyc[0] = 1'b0;
    slot(1'b0, 6'd0);
    slot(1'b0, 6'd0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
